// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - N:1 AXI4 burst arbiter; read and write paths arbitrate independently.
// Build option AXI_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module axi_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]    up_awid_i,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]  up_awaddr_i,
  input  logic [NUM_MASTERS*8-1:0]               up_awlen_i,
  input  logic [NUM_MASTERS*3-1:0]               up_awsize_i,
  input  logic [NUM_MASTERS*2-1:0]               up_awburst_i,
  input  logic [NUM_MASTERS-1:0]                 up_awvalid_i,
  output logic [NUM_MASTERS-1:0]                 up_awready_o,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]  up_wdata_i,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH/8-1:0] up_wstrb_i,
  input  logic [NUM_MASTERS-1:0]                 up_wlast_i,
  input  logic [NUM_MASTERS-1:0]                 up_wvalid_i,
  output logic [NUM_MASTERS-1:0]                 up_wready_o,
  output logic [AXI_ID_WIDTH-1:0]                up_bid_o,
  output logic [1:0]                             up_bresp_o,
  output logic [NUM_MASTERS-1:0]                 up_bvalid_o,
  input  logic [NUM_MASTERS-1:0]                 up_bready_i,
  input  logic [NUM_MASTERS*AXI_ID_WIDTH-1:0]    up_arid_i,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]  up_araddr_i,
  input  logic [NUM_MASTERS*8-1:0]               up_arlen_i,
  input  logic [NUM_MASTERS*3-1:0]               up_arsize_i,
  input  logic [NUM_MASTERS*2-1:0]               up_arburst_i,
  input  logic [NUM_MASTERS-1:0]                 up_arvalid_i,
  output logic [NUM_MASTERS-1:0]                 up_arready_o,
  output logic [AXI_ID_WIDTH-1:0]                up_rid_o,
  output logic [AXI_DATA_WIDTH-1:0]              up_rdata_o,
  output logic [1:0]                             up_rresp_o,
  output logic                                   up_rlast_o,
  output logic [NUM_MASTERS-1:0]                 up_rvalid_o,
  input  logic [NUM_MASTERS-1:0]                 up_rready_i,
  output logic [AXI_ID_WIDTH-1:0]                dn_awid_o,
  output logic [AXI_ADDR_WIDTH-1:0]              dn_awaddr_o,
  output logic [7:0]                             dn_awlen_o,
  output logic [2:0]                             dn_awsize_o,
  output logic [1:0]                             dn_awburst_o,
  output logic                                   dn_awvalid_o,
  input  logic                                   dn_awready_i,
  output logic [AXI_DATA_WIDTH-1:0]              dn_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0]            dn_wstrb_o,
  output logic                                   dn_wlast_o,
  output logic                                   dn_wvalid_o,
  input  logic                                   dn_wready_i,
  input  logic [AXI_ID_WIDTH-1:0]                dn_bid_i,
  input  logic [1:0]                             dn_bresp_i,
  input  logic                                   dn_bvalid_i,
  output logic                                   dn_bready_o,
  output logic [AXI_ID_WIDTH-1:0]                dn_arid_o,
  output logic [AXI_ADDR_WIDTH-1:0]              dn_araddr_o,
  output logic [7:0]                             dn_arlen_o,
  output logic [2:0]                             dn_arsize_o,
  output logic [1:0]                             dn_arburst_o,
  output logic                                   dn_arvalid_o,
  input  logic                                   dn_arready_i,
  input  logic [AXI_ID_WIDTH-1:0]                dn_rid_i,
  input  logic [AXI_DATA_WIDTH-1:0]              dn_rdata_i,
  input  logic [1:0]                             dn_rresp_i,
  input  logic                                   dn_rlast_i,
  input  logic                                   dn_rvalid_i,
  output logic                                   dn_rready_o
);

  localparam int N  = NUM_MASTERS;
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int IW = AXI_ID_WIDTH;
  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  wstate_e         wstate_q, wstate_d;
  rstate_e         rstate_q, rstate_d;
  logic [GW-1:0]   wgnt_q, wgnt_d, rgnt_q, rgnt_d;
  logic [GW-1:0]   wwin, rwin;
  logic            w_done, r_done;

`ifdef AXI_ARB_FIXED_PRIO_EN
  function automatic logic [GW-1:0] fp_pick(input logic [N-1:0] req);
    logic [GW-1:0] win;
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) win = GW'(k);
    end
    return win;
  endfunction

  assign wwin = fp_pick(up_awvalid_i);
  assign rwin = fp_pick(up_arvalid_i);
`else
  logic [GW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

  // Scan from the far end so the last hit is the first requester after ptr.
  function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0] win;
    int            idx;
    win = ptr;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) win = GW'(idx);
    end
    return win;
  endfunction

  assign wwin   = rr_pick(up_awvalid_i, wptr_q);
  assign rwin   = rr_pick(up_arvalid_i, rptr_q);
  assign wptr_d = w_done ? wgnt_q : wptr_q;
  assign rptr_d = r_done ? rgnt_q : rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= GW'(N - 1);
      rptr_q <= GW'(N - 1);
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
`endif

  // Request payloads follow the registered grant only, so they hold steady under valid.
  assign dn_awid_o    = up_awid_i[wgnt_q*IW +: IW];
  assign dn_awaddr_o  = up_awaddr_i[wgnt_q*AW +: AW];
  assign dn_awlen_o   = up_awlen_i[wgnt_q*8 +: 8];
  assign dn_awsize_o  = up_awsize_i[wgnt_q*3 +: 3];
  assign dn_awburst_o = up_awburst_i[wgnt_q*2 +: 2];
  assign dn_wdata_o   = up_wdata_i[wgnt_q*DW +: DW];
  assign dn_wstrb_o   = up_wstrb_i[wgnt_q*SW +: SW];
  assign dn_wlast_o   = up_wlast_i[wgnt_q];
  assign dn_arid_o    = up_arid_i[rgnt_q*IW +: IW];
  assign dn_araddr_o  = up_araddr_i[rgnt_q*AW +: AW];
  assign dn_arlen_o   = up_arlen_i[rgnt_q*8 +: 8];
  assign dn_arsize_o  = up_arsize_i[rgnt_q*3 +: 3];
  assign dn_arburst_o = up_arburst_i[rgnt_q*2 +: 2];

  assign up_bid_o   = dn_bid_i;
  assign up_bresp_o = dn_bresp_i;
  assign up_rid_o   = dn_rid_i;
  assign up_rdata_o = dn_rdata_i;
  assign up_rresp_o = dn_rresp_i;
  assign up_rlast_o = dn_rlast_i;

  always_comb begin
    wstate_d     = wstate_q;
    wgnt_d       = wgnt_q;
    w_done       = 1'b0;
    up_awready_o = '0;
    up_wready_o  = '0;
    up_bvalid_o  = '0;
    dn_awvalid_o = 1'b0;
    dn_wvalid_o  = 1'b0;
    dn_bready_o  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (|up_awvalid_i) begin
          wgnt_d   = wwin;
          wstate_d = W_ADDR;
        end
      end
      W_ADDR: begin
        dn_awvalid_o         = 1'b1;
        up_awready_o[wgnt_q] = dn_awready_i;
        if (dn_awready_i) wstate_d = W_DATA;
      end
      W_DATA: begin
        dn_wvalid_o         = up_wvalid_i[wgnt_q];
        up_wready_o[wgnt_q] = dn_wready_i;
        if (up_wvalid_i[wgnt_q] && dn_wready_i && up_wlast_i[wgnt_q]) wstate_d = W_RESP;
      end
      W_RESP: begin
        up_bvalid_o[wgnt_q] = dn_bvalid_i;
        dn_bready_o         = up_bready_i[wgnt_q];
        if (dn_bvalid_i && up_bready_i[wgnt_q]) begin
          w_done   = 1'b1;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d     = rstate_q;
    rgnt_d       = rgnt_q;
    r_done       = 1'b0;
    up_arready_o = '0;
    up_rvalid_o  = '0;
    dn_arvalid_o = 1'b0;
    dn_rready_o  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (|up_arvalid_i) begin
          rgnt_d   = rwin;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        dn_arvalid_o         = 1'b1;
        up_arready_o[rgnt_q] = dn_arready_i;
        if (dn_arready_i) rstate_d = R_DATA;
      end
      R_DATA: begin
        up_rvalid_o[rgnt_q] = dn_rvalid_i;
        dn_rready_o         = up_rready_i[rgnt_q];
        if (dn_rvalid_i && up_rready_i[rgnt_q] && dn_rlast_i) begin
          r_done   = 1'b1;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      wgnt_q   <= '0;
      rgnt_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wgnt_q   <= wgnt_d;
      rgnt_q   <= rgnt_d;
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb/tb_axi_rr_arbiter.sv - directed bench for axi_rr_arbiter with a small memory slave model.
module tb_axi_rr_arbiter;
  localparam int N = 2, AW = 40, DW = 32, IW = 4, SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [N*IW-1:0] up_awid, up_arid;
  logic [N*AW-1:0] up_awaddr, up_araddr;
  logic [N*8-1:0]  up_awlen, up_arlen;
  logic [N*3-1:0]  up_awsize, up_arsize;
  logic [N*2-1:0]  up_awburst, up_arburst;
  logic [N-1:0]    up_awvalid, up_awready, up_arvalid, up_arready;
  logic [N*DW-1:0] up_wdata;
  logic [N*SW-1:0] up_wstrb;
  logic [N-1:0]    up_wlast, up_wvalid, up_wready;
  logic [IW-1:0]   up_bid, up_rid;
  logic [1:0]      up_bresp, up_rresp;
  logic [N-1:0]    up_bvalid, up_bready, up_rvalid, up_rready;
  logic [DW-1:0]   up_rdata;
  logic            up_rlast;

  logic [IW-1:0] dn_awid, dn_arid, dn_bid, dn_rid;
  logic [AW-1:0] dn_awaddr, dn_araddr;
  logic [7:0]    dn_awlen, dn_arlen;
  logic [2:0]    dn_awsize, dn_arsize;
  logic [1:0]    dn_awburst, dn_arburst, dn_bresp, dn_rresp;
  logic          dn_awvalid, dn_arvalid, dn_wvalid, dn_wlast, dn_bvalid, dn_bready;
  logic          dn_rvalid, dn_rready, dn_rlast;
  logic [DW-1:0] dn_wdata, dn_rdata;
  logic [SW-1:0] dn_wstrb;
  logic          dn_awready = 1'b1, dn_wready = 1'b1, dn_arready = 1'b1;

  logic [IW-1:0] m_awid[N], m_arid[N];
  logic [AW-1:0] m_awaddr[N], m_araddr[N];
  logic [7:0]    m_awlen[N], m_arlen[N];
  logic          m_awvalid[N], m_arvalid[N], m_wvalid[N], m_wlast[N], m_bready[N], m_rready[N];
  logic [DW-1:0] m_wdata[N];

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign up_awid[g*IW +: IW]   = m_awid[g];
    assign up_awaddr[g*AW +: AW] = m_awaddr[g];
    assign up_awlen[g*8 +: 8]    = m_awlen[g];
    assign up_awsize[g*3 +: 3]   = 3'd2;
    assign up_awburst[g*2 +: 2]  = 2'b01;
    assign up_awvalid[g]         = m_awvalid[g];
    assign up_wdata[g*DW +: DW]  = m_wdata[g];
    assign up_wstrb[g*SW +: SW]  = {SW{1'b1}};
    assign up_wlast[g]           = m_wlast[g];
    assign up_wvalid[g]          = m_wvalid[g];
    assign up_bready[g]          = m_bready[g];
    assign up_arid[g*IW +: IW]   = m_arid[g];
    assign up_araddr[g*AW +: AW] = m_araddr[g];
    assign up_arlen[g*8 +: 8]    = m_arlen[g];
    assign up_arsize[g*3 +: 3]   = 3'd2;
    assign up_arburst[g*2 +: 2]  = 2'b01;
    assign up_arvalid[g]         = m_arvalid[g];
    assign up_rready[g]          = m_rready[g];
  end

  axi_rr_arbiter #(.NUM_MASTERS(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_awid_i(up_awid), .up_awaddr_i(up_awaddr), .up_awlen_i(up_awlen), .up_awsize_i(up_awsize),
    .up_awburst_i(up_awburst), .up_awvalid_i(up_awvalid), .up_awready_o(up_awready),
    .up_wdata_i(up_wdata), .up_wstrb_i(up_wstrb), .up_wlast_i(up_wlast), .up_wvalid_i(up_wvalid),
    .up_wready_o(up_wready), .up_bid_o(up_bid), .up_bresp_o(up_bresp), .up_bvalid_o(up_bvalid),
    .up_bready_i(up_bready),
    .up_arid_i(up_arid), .up_araddr_i(up_araddr), .up_arlen_i(up_arlen), .up_arsize_i(up_arsize),
    .up_arburst_i(up_arburst), .up_arvalid_i(up_arvalid), .up_arready_o(up_arready),
    .up_rid_o(up_rid), .up_rdata_o(up_rdata), .up_rresp_o(up_rresp), .up_rlast_o(up_rlast),
    .up_rvalid_o(up_rvalid), .up_rready_i(up_rready),
    .dn_awid_o(dn_awid), .dn_awaddr_o(dn_awaddr), .dn_awlen_o(dn_awlen), .dn_awsize_o(dn_awsize),
    .dn_awburst_o(dn_awburst), .dn_awvalid_o(dn_awvalid), .dn_awready_i(dn_awready),
    .dn_wdata_o(dn_wdata), .dn_wstrb_o(dn_wstrb), .dn_wlast_o(dn_wlast), .dn_wvalid_o(dn_wvalid),
    .dn_wready_i(dn_wready), .dn_bid_i(dn_bid), .dn_bresp_i(dn_bresp), .dn_bvalid_i(dn_bvalid),
    .dn_bready_o(dn_bready),
    .dn_arid_o(dn_arid), .dn_araddr_o(dn_araddr), .dn_arlen_o(dn_arlen), .dn_arsize_o(dn_arsize),
    .dn_arburst_o(dn_arburst), .dn_arvalid_o(dn_arvalid), .dn_arready_i(dn_arready),
    .dn_rid_i(dn_rid), .dn_rdata_i(dn_rdata), .dn_rresp_i(dn_rresp), .dn_rlast_i(dn_rlast),
    .dn_rvalid_i(dn_rvalid), .dn_rready_o(dn_rready)
  );

  // Slave: always-ready memory, one outstanding write and one outstanding read.
  logic [DW-1:0] smem[256];
  logic [DW-1:0] exp_mem[256];
  logic [7:0]    s_wbase, s_wcnt, s_rbase, s_rbeat, s_rlen;
  logic [IW-1:0] s_bid, s_rid;
  logic          s_bpend, s_ract;
  logic [AW-1:0] s_awaddr;
  logic [7:0]    s_awlen;
  logic [2:0]    s_awsize, s_arsize;
  logic [1:0]    s_awburst, s_arburst;
  int            dn_aw_cnt = 0, dn_w_cnt = 0, strb_bad = 0;

  initial for (int i = 0; i < 256; i++) smem[i] = 32'hC0DE_0000 | i;

  assign dn_bvalid = s_bpend;
  assign dn_bid    = s_bid;
  assign dn_bresp  = 2'b00;
  assign dn_rvalid = s_ract;
  assign dn_rid    = s_rid;
  assign dn_rresp  = 2'b00;
  assign dn_rdata  = smem[8'(s_rbase + s_rbeat)];
  assign dn_rlast  = (s_rbeat == s_rlen);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_wbase <= '0; s_wcnt <= '0; s_bpend <= 1'b0; s_bid <= '0;
      s_rbase <= '0; s_rbeat <= '0; s_rlen <= '0; s_ract <= 1'b0; s_rid <= '0;
    end else begin
      if (dn_awvalid && dn_awready) begin
        s_wbase <= dn_awaddr[9:2]; s_bid <= dn_awid; s_wcnt <= '0;
      end
      if (dn_wvalid && dn_wready) begin
        smem[8'(s_wbase + s_wcnt)] <= dn_wdata;
        s_wcnt <= s_wcnt + 8'd1;
        if (dn_wlast) s_bpend <= 1'b1;
      end
      if (s_bpend && dn_bready) s_bpend <= 1'b0;
      if (dn_arvalid && dn_arready) begin
        s_rbase <= dn_araddr[9:2]; s_rlen <= dn_arlen; s_rid <= dn_arid;
        s_rbeat <= '0; s_ract <= 1'b1;
      end
      if (s_ract && dn_rready) begin
        if (s_rbeat == s_rlen) s_ract <= 1'b0;
        else s_rbeat <= s_rbeat + 8'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (dn_awvalid && dn_awready) begin
      dn_aw_cnt <= dn_aw_cnt + 1;
      s_awaddr <= dn_awaddr; s_awlen <= dn_awlen; s_awsize <= dn_awsize; s_awburst <= dn_awburst;
    end
    if (dn_arvalid && dn_arready) begin
      s_arsize <= dn_arsize; s_arburst <= dn_arburst;
    end
    if (dn_wvalid && dn_wready) begin
      dn_w_cnt <= dn_w_cnt + 1;
      if (dn_wstrb !== {SW{1'b1}}) strb_bad <= strb_bad + 1;
    end
  end

  // Handshake monitor: sampled mid-cycle, the edge that follows completes the transfer.
  int  aw_code = 0, ar_code = 0;
  int  rhs[N], bv_cyc[N];
  time aw_t[N], b_t[N];
  initial for (int i = 0; i < N; i++) begin rhs[i] = 0; bv_cyc[i] = 0; aw_t[i] = 0; b_t[i] = 0; end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < N; m++) begin
        if (m_awvalid[m] && up_awready[m]) begin aw_code = aw_code*10 + m + 1; aw_t[m] = $time; end
        if (m_arvalid[m] && up_arready[m]) ar_code = ar_code*10 + m + 1;
        if (m_bready[m] && up_bvalid[m]) b_t[m] = $time;
        if (m_rready[m] && up_rvalid[m]) rhs[m] = rhs[m] + 1;
        if (up_bvalid[m]) bv_cyc[m] = bv_cyc[m] + 1;
      end
    end
  end

  function automatic bit sig(input int which, input int m);
    case (which)
      0: return up_awready[m];
      1: return up_wready[m];
      2: return up_bvalid[m];
      3: return up_arready[m];
      default: return up_rvalid[m];
    endcase
  endfunction

  task automatic wait_sig(input int which, input int m);
    int c;
    @(negedge clk);
    for (c = 0; c < 200 && !sig(which, m); c++) @(negedge clk);
    checks++;
    if (c >= 200) begin
      errors++;
      $display("FAIL timeout chan=%0d master=%0d: waited %0d cycles, required < 200", which, m, c);
    end
  endtask

  task automatic m_write(input int m, input logic [AW-1:0] addr, input int len,
                         input logic [DW-1:0] seed, input int gap);
    m_awid[m] = IW'(m + 1); m_awaddr[m] = addr; m_awlen[m] = 8'(len); m_awvalid[m] = 1'b1;
    wait_sig(0, m);
    @(posedge clk); #1;
    m_awvalid[m] = 1'b0;
    for (int i = 0; i <= len; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      m_wdata[m] = seed + DW'(i); m_wlast[m] = (i == len); m_wvalid[m] = 1'b1;
      exp_mem[addr[9:2] + i] = seed + DW'(i);
      wait_sig(1, m);
      @(posedge clk); #1;
      m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
    end
    m_bready[m] = 1'b1;
    wait_sig(2, m);
    checks++;
    if (up_bid !== IW'(m + 1) || up_bresp !== 2'b00) begin
      errors++;
      $display("FAIL bresp m%0d: bid=%0h resp=%0h, required bid=%0h resp=0", m, up_bid, up_bresp, m + 1);
    end
    @(posedge clk); #1;
    m_bready[m] = 1'b0;
  endtask

  task automatic m_read(input int m, input logic [AW-1:0] addr, input int len, input int stall_at);
    m_arid[m] = IW'(m + 5); m_araddr[m] = addr; m_arlen[m] = 8'(len); m_arvalid[m] = 1'b1;
    wait_sig(3, m);
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0;
    m_rready[m] = 1'b1;
    for (int i = 0; i <= len; i++) begin
      if (i == stall_at) begin
        m_rready[m] = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (dn_rready !== 1'b0) begin
            errors++;
            $display("FAIL stall_rready m%0d: dn_rready=%b, required 0", m, dn_rready);
          end
        end
        @(posedge clk); #1;
        m_rready[m] = 1'b1;
      end
      wait_sig(4, m);
      checks++;
      if (up_rdata !== exp_mem[addr[9:2] + i] || up_rlast !== (i == len) ||
          up_rid !== IW'(m + 5) || up_rresp !== 2'b00) begin
        errors++;
        $display("FAIL rbeat m%0d beat %0d: data=%0h last=%b id=%0h, required data=%0h last=%b id=%0h",
                 m, i, up_rdata, up_rlast, up_rid, exp_mem[addr[9:2] + i], (i == len), m + 5);
      end
      @(posedge clk); #1;
    end
    m_rready[m] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_awvalid[0] = 1'b1;
    m_arvalid[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({up_awready, up_wready, up_bvalid, up_arready, up_rvalid} !== '0) begin
      errors++;
      $display("FAIL reset_up: up ready/valid=%b, required 0",
               {up_awready, up_wready, up_bvalid, up_arready, up_rvalid});
    end
    checks++;
    if ({dn_awvalid, dn_wvalid, dn_bready, dn_arvalid, dn_rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_dn: dn valid/ready=%b, required 00000",
               {dn_awvalid, dn_wvalid, dn_bready, dn_arvalid, dn_rready});
    end
    m_awvalid[0] = 1'b0;
    m_arvalid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int aw0, w0, bv0;
    aw0 = dn_aw_cnt; w0 = dn_w_cnt; bv0 = bv_cyc[0];
    m_write(1, 40'h100, 3, 32'h1100_0000, 0);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (dn_aw_cnt - aw0 != 1 || dn_w_cnt - w0 != 4) begin
      errors++;
      $display("FAIL single_counts: aw=%0d w=%0d, required aw=1 w=4", dn_aw_cnt - aw0, dn_w_cnt - w0);
    end
    checks++;
    if (s_awaddr !== 40'h100 || s_awlen !== 8'd3 || s_awsize !== 3'd2 || s_awburst !== 2'b01) begin
      errors++;
      $display("FAIL single_aw: addr=%0h len=%0d size=%0d burst=%0d, required 100 3 2 1",
               s_awaddr, s_awlen, s_awsize, s_awburst);
    end
    checks++;
    if (bv_cyc[0] != bv0 || strb_bad != 0) begin
      errors++;
      $display("FAIL single_b_m0: m0 bvalid cycles=%0d strb_bad=%0d, required 0 0", bv_cyc[0] - bv0, strb_bad);
    end
  endtask

  task automatic test_read_contention();
    ar_code = 0;
    for (int r = 0; r < 3; r++) begin
      fork
        m_read(0, 40'h100, 0, -1);
        m_read(1, 40'h108, 0, -1);
      join
    end
    checks++;
    if (ar_code != 121212) begin
      errors++;
      $display("FAIL rr_read_order: order code=%0d, required 121212", ar_code);
    end
    checks++;
    if (s_arsize !== 3'd2 || s_arburst !== 2'b01) begin
      errors++;
      $display("FAIL ar_payload: size=%0d burst=%0d, required 2 1", s_arsize, s_arburst);
    end
  endtask

  task automatic test_concurrent_rw();
    int r0, bv1, w0;
    r0 = rhs[0]; bv1 = bv_cyc[1]; w0 = dn_w_cnt;
    fork
      m_write(0, 40'h200, 7, 32'h3300_0000, 0);
      m_read(1, 40'h100, 7, -1);
    join
    checks++;
    if (rhs[0] != r0 || bv_cyc[1] != bv1 || dn_w_cnt - w0 != 8) begin
      errors++;
      $display("FAIL concurrent_routing: m0 r=%0d m1 bvalid=%0d w=%0d, required 0 0 8",
               rhs[0] - r0, bv_cyc[1] - bv1, dn_w_cnt - w0);
    end
  endtask

  task automatic test_aw_waits_for_b();
    aw_code = 0;
    fork
      m_write(1, 40'h300, 3, 32'h4400_0000, 3);
      begin
        for (int c = 0; c < 200 && aw_code == 0; c++) @(negedge clk);
        @(posedge clk); #1;
        m_write(0, 40'h340, 1, 32'h4500_0000, 0);
      end
    join
    checks++;
    if (aw_code != 21 || aw_t[0] <= b_t[1]) begin
      errors++;
      $display("FAIL aw_waits: order=%0d m0 aw at %0t m1 b at %0t, required order 21 and aw after b",
               aw_code, aw_t[0], b_t[1]);
    end
  endtask

  task automatic test_rready_stall();
    int r0;
    r0 = rhs[0];
    m_read(0, 40'h200, 7, 3);
    checks++;
    if (rhs[0] - r0 != 8) begin
      errors++;
      $display("FAIL stall_beats: beats=%0d, required 8", rhs[0] - r0);
    end
  endtask

  task automatic test_priority_mode();
    ar_code = 0;
    fork
      for (int k = 0; k < 3; k++) m_read(0, 40'h300, 1, -1);
      m_read(1, 40'h340, 0, -1);
    join
    checks++;
`ifdef AXI_ARB_FIXED_PRIO_EN
    if (ar_code != 1112) begin
      errors++;
      $display("FAIL fixed_prio_order: code=%0d, required 1112", ar_code);
    end
`else
    if (ar_code != 2111) begin
      errors++;
      $display("FAIL rr_fair_order: code=%0d, required 2111", ar_code);
    end
`endif
  endtask

  task automatic test_reset_midburst();
    m_arid[0] = 4'h5; m_araddr[0] = 40'h100; m_arlen[0] = 8'd3; m_arvalid[0] = 1'b1;
    wait_sig(3, 0);
    @(posedge clk); #1;
    m_arvalid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (up_rvalid !== '0 || dn_rready !== 1'b0 || dn_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset: up_rvalid=%b dn_rready=%b dn_arvalid=%b, required 0",
               up_rvalid, dn_rready, dn_arvalid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_read(1, 40'h200, 1, -1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'hC0DE_0000 | i;
    for (int m = 0; m < N; m++) begin
      m_awid[m] = '0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awvalid[m] = 1'b0;
      m_wdata[m] = '0; m_wlast[m] = 1'b0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b0;
      m_arid[m] = '0; m_araddr[m] = '0; m_arlen[m] = '0; m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
    end
    test_reset();
    test_single_write();
    test_read_contention();
    test_concurrent_rw();
    test_aw_waits_for_b();
    test_rready_stall();
    test_priority_mode();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
